id_hazard_ctrl: RTL and testbench
=================================

# id_hazard_ctrl

Hazard and branch sequencing controller for the ID stage of the 5-stage MIPS pipeline. It keeps its own shadow copy of the destination-register information in EX, MEM and WB. From that it decides, each cycle:

- whether the instruction in ID must stall;
- which source feeds each operand of the ID-stage equality comparator (register file, EX/MEM or MEM/WB);
- whether a branch resolved in ID is taken, which redirects the PC and squashes IF/ID.

It sits beside the ID stage and drives the PC/IF-ID write enables, the ID/EX bubble mux and the comparator operand muxes.

## Interface
- REG_ADDR_W, 5, register-specifier width
- CNT_W, 16, width of the stall performance counter
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ext_hold  in  1  global pipeline freeze (e.g. memory wait); nothing advances
- id_valid  in  1  IF/ID holds a real instruction
- id_rs, id_rt  in  REG_ADDR_W  source specifiers of the ID instruction
- id_uses_rs, id_uses_rt  in  1  the instruction reads that source
- id_is_branch  in  1  beq/bne, compared in ID
- id_is_bne  in  1  branch sense: 1 = bne, 0 = beq
- id_zero  in  1  ID comparator result (operands equal, after forwarding)
- id_dst  in  REG_ADDR_W  destination specifier (already RegDst-selected)
- id_reg_write, id_mem_read  in  1  the ID instruction writes a register / is a load
- stall_id  out  1  hold PC and IF/ID this cycle
- bubble_ex  out  1  load a NOP into ID/EX at the next edge
- branch_taken  out  1  select the branch target for PC; squash IF/ID
- fwd_a_sel, fwd_b_sel  out  2  comparator operand source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB write data
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation

**Shadow entries**
- Three registered entries: EX, MEM, WB. Each holds {valid, dst, wr, ld}.
- wr is forced to 0 when dst == 0.

**Producer match**
- A source s "matches" stage X when: the source is used, s != 0, X.valid, X.wr, and X.dst == s.

**Stall conditions**
- Non-branch consumer: stall if EX matches and EX.ld is set (load-use, 1 cycle).
- Branch consumer: stall if EX matches (any producer).
- Branch consumer: also stall if MEM matches and MEM.ld is set.
- Resulting stall lengths: ALU followed by branch = 1 cycle; load followed by branch = 2 cycles.
- stall_id = bubble_ex = id_valid & (any stall condition) & !ext_hold.

**Forwarding, per operand (branch only; otherwise 00)**
- MEM matches and !MEM.ld → 01.
- Otherwise, WB matches → 10.
- Otherwise → 00.
- The nearer stage wins.
- The register file writes at the clock edge, so a WB producer always needs 10.

**Branch outcome**
- branch_taken = id_valid & id_is_branch & !stall_id & !ext_hold & (id_is_bne ? !id_zero : id_zero).

**Shadow advance** (every rising edge, when !ext_hold)
- WB ← MEM; MEM ← EX.
- EX ← bubble (valid = 0) if stall_id or !id_valid.
- Otherwise EX ← {1, id_dst, id_reg_write, id_mem_read}.
- A taken branch advances normally: it has wr = 0.

**Freeze**
- While ext_hold = 1: all entries and stall_count hold.
- All outputs except fwd_*_sel and stall_count are 0.

**stall_count**
- Increments on each edge where stall_id = 1.
- Saturates at all-ones.

## Timing
- All outputs are combinational from the registered shadow entries plus the current ID inputs: zero-cycle latency, settled before the next edge.
- Shadow entries and the counter update at the rising edge.

**Reset**
- Asynchronous assertion (rst = 0) clears all shadow entries to invalid and stall_count to 0.
- While rst = 0, all outputs are forced low: stall_id = 0, bubble_ex = 0, branch_taken = 0, fwd_*_sel = 00, stall_count = 0.
- Reset mid-stall cancels the stall immediately. After release, the first edge samples the ID inputs normally.

**Stall sequencing**
- Consecutive stall cycles re-evaluate against the advancing shadow.
- A load→branch stall therefore drops after exactly 2 edges with no extra state.

**Boundary cases**
- Writes to $0 never stall and never forward.
- When the same register is matched in both MEM (ALU) and WB, 01 is selected.
- A stall and a taken branch can never assert together; the stall wins.

## Test plan
- **Load-use, non-branch.** lw $8 (EX), add using $8 in ID → stall_id = 1 for 1 cycle, then 0. The EX entry on the next edge is invalid. stall_count = 1.
- **ALU→beq.** add $9 in EX, beq $9,$9 in ID → 1 stall cycle. Next cycle fwd_a_sel = fwd_b_sel = 01. With id_zero = 1: branch_taken = 1.
- **Load→bne.** lw $10 in EX, bne $10,$0 → stall for 2 cycles. On the third cycle fwd_a_sel = 10, fwd_b_sel = 00. With id_zero = 0: branch_taken = 1.
- **$0 destination.** add $0 in EX, beq $0,$0 → no stall, fwd = 00/00, branch_taken = 1.
- **ext_hold during load→branch.** ext_hold = 1 for 3 cycles mid-stall → shadow and stall_count frozen, outputs low. After release, the remaining stall cycle appears.
- **Reset and saturation.** Drop rst during a stall → outputs 0 immediately, stall_count = 0. Separately, 2^CNT_W + 5 stalls → stall_count = all-ones.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: ID-stage stall, branch-operand forwarding and branch resolution from shadowed EX/MEM/WB destinations
module id_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ext_hold,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_is_branch,
  input  logic                  id_is_bne,
  input  logic                  id_zero,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  branch_taken,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_count
);
  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] d;
    logic                  wr;
    logic                  ld;
  } ent_t;
  ent_t ex, mem, wb;
  logic [CNT_W-1:0] cnt;
  logic a_ex, b_ex, a_mem, b_mem, a_wb, b_wb, hit;
  function automatic logic hit_on(input logic u, input logic [REG_ADDR_W-1:0] s, input ent_t e);
    return u && s != '0 && e.v && e.wr && e.d == s;
  endfunction
  always_comb begin
    a_ex = hit_on(id_uses_rs, id_rs, ex);
    b_ex = hit_on(id_uses_rt, id_rt, ex);
    a_mem = hit_on(id_uses_rs, id_rs, mem);
    b_mem = hit_on(id_uses_rt, id_rt, mem);
    a_wb = hit_on(id_uses_rs, id_rs, wb);
    b_wb = hit_on(id_uses_rt, id_rt, wb);
    // branches compare in ID, so any EX producer and a load in MEM are both too late
    hit = id_is_branch ? (a_ex | b_ex | ((a_mem | b_mem) & mem.ld)) : ((a_ex | b_ex) & ex.ld);
    stall_id = rst & id_valid & hit & !ext_hold;
    bubble_ex = stall_id;
    branch_taken = rst & id_valid & id_is_branch & !stall_id & !ext_hold & (id_is_bne ? !id_zero : id_zero);
    fwd_a_sel = !(rst && id_is_branch) ? 2'b00 : (a_mem && !mem.ld) ? 2'b01 : a_wb ? 2'b10 : 2'b00;
    fwd_b_sel = !(rst && id_is_branch) ? 2'b00 : (b_mem && !mem.ld) ? 2'b01 : b_wb ? 2'b10 : 2'b00;
    stall_count = rst ? cnt : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ex <= '0;
      mem <= '0;
      wb <= '0;
      cnt <= '0;
    end else if (!ext_hold) begin
      wb <= mem;
      mem <= ex;
      ex <= (stall_id || !id_valid) ? '0 : ent_t'{1'b1, id_dst, id_reg_write && id_dst != '0, id_mem_read};
      if (stall_id && cnt != '1) cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: directed scenario tasks with hand-computed expectations for id_hazard_ctrl
module tb_id_hazard_ctrl;
  localparam int CW = 8;
  logic clk = 0, rst = 0, ext_hold = 0;
  logic id_valid = 0, id_uses_rs = 0, id_uses_rt = 0, id_is_branch = 0, id_is_bne = 0, id_zero = 0;
  logic id_reg_write = 0, id_mem_read = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_dst = 0;
  logic stall_id, bubble_ex, branch_taken;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] exp_cnt = 0;
  int n = 0, fails = 0;

  id_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ext_hold(ext_hold), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_is_bne(id_is_bne), .id_zero(id_zero),
    .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .stall_id(stall_id), .bubble_ex(bubble_ex), .branch_taken(branch_taken),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_count(stall_count));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                     input logic urt, input logic br, input logic bne, input logic z,
                     input logic [4:0] dst, input logic wr, input logic ld);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_is_branch = br; id_is_bne = bne; id_zero = z; id_dst = dst; id_reg_write = wr; id_mem_read = ld;
    #1;
  endtask

  task automatic flush();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    drv(1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0);
    n++; if (branch_taken !== 1'b0) begin fails++; $display("FAIL rst_taken got %b exp 0", branch_taken); end
    n++; if (stall_count !== '0) begin fails++; $display("FAIL rst_cnt got %0d exp 0", stall_count); end
    n++; if ({stall_id, bubble_ex, fwd_a_sel, fwd_b_sel} !== 6'b0) begin fails++; $display("FAIL rst_outs got %b exp 000000", {stall_id, bubble_ex, fwd_a_sel, fwd_b_sel}); end
    rst = 1;
    flush();
  endtask

  task automatic test_load_use();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 8, 1, 1);
    n++; if (stall_id !== 1'b0) begin fails++; $display("FAIL lu_lw_stall got %b exp 0", stall_id); end
    tick();
    drv(1, 8, 3, 1, 1, 0, 0, 0, 11, 1, 0);
    n++; if ({stall_id, bubble_ex} !== 2'b11) begin fails++; $display("FAIL lu_stall got %b exp 11", {stall_id, bubble_ex}); end
    tick(); exp_cnt++;
    n++; if (stall_id !== 1'b0) begin fails++; $display("FAIL lu_release got %b exp 0", stall_id); end
    n++; if (stall_count !== exp_cnt) begin fails++; $display("FAIL lu_cnt got %0d exp %0d", stall_count, exp_cnt); end
    drv(1, 11, 11, 1, 1, 1, 0, 1, 0, 0, 0);
    n++; if (stall_id !== 1'b0) begin fails++; $display("FAIL lu_ex_bubbled got %b exp 0", stall_id); end
    flush();
  endtask

  task automatic test_alu_beq();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 9, 1, 0);
    tick();
    drv(1, 9, 9, 1, 1, 1, 0, 1, 0, 0, 0);
    n++; if ({stall_id, branch_taken} !== 2'b10) begin fails++; $display("FAIL ab_stall got %b exp 10", {stall_id, branch_taken}); end
    tick(); exp_cnt++;
    n++; if (stall_id !== 1'b0) begin fails++; $display("FAIL ab_release got %b exp 0", stall_id); end
    n++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0101) begin fails++; $display("FAIL ab_fwd got %b exp 0101", {fwd_a_sel, fwd_b_sel}); end
    n++; if (branch_taken !== 1'b1) begin fails++; $display("FAIL ab_taken got %b exp 1", branch_taken); end
    flush();
  endtask

  task automatic test_load_bne();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 10, 1, 1);
    tick();
    drv(1, 10, 0, 1, 1, 1, 1, 0, 0, 0, 0);
    n++; if (stall_id !== 1'b1) begin fails++; $display("FAIL lb_stall1 got %b exp 1", stall_id); end
    tick(); exp_cnt++;
    n++; if ({stall_id, branch_taken} !== 2'b10) begin fails++; $display("FAIL lb_stall2 got %b exp 10", {stall_id, branch_taken}); end
    tick(); exp_cnt++;
    n++; if (stall_id !== 1'b0) begin fails++; $display("FAIL lb_release got %b exp 0", stall_id); end
    n++; if ({fwd_a_sel, fwd_b_sel} !== 4'b1000) begin fails++; $display("FAIL lb_fwd got %b exp 1000", {fwd_a_sel, fwd_b_sel}); end
    n++; if (branch_taken !== 1'b1) begin fails++; $display("FAIL lb_taken got %b exp 1", branch_taken); end
    n++; if (stall_count !== exp_cnt) begin fails++; $display("FAIL lb_cnt got %0d exp %0d", stall_count, exp_cnt); end
    flush();
  endtask

  task automatic test_zero_dst();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    drv(1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0);
    n++; if ({stall_id, fwd_a_sel, fwd_b_sel, branch_taken} !== 6'b000001) begin fails++; $display("FAIL z0_branch got %b exp 000001", {stall_id, fwd_a_sel, fwd_b_sel, branch_taken}); end
    tick();
    n++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin fails++; $display("FAIL z0_nofwd got %b exp 0000", {fwd_a_sel, fwd_b_sel}); end
    flush();
  endtask

  task automatic test_ext_hold();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 12, 1, 1);
    tick();
    drv(1, 12, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    tick(); exp_cnt++;
    n++; if (stall_id !== 1'b1) begin fails++; $display("FAIL eh_prehold got %b exp 1", stall_id); end
    ext_hold = 1; #1;
    n++; if ({stall_id, bubble_ex, branch_taken} !== 3'b000) begin fails++; $display("FAIL eh_outs got %b exp 000", {stall_id, bubble_ex, branch_taken}); end
    repeat (3) tick();
    n++; if (stall_count !== exp_cnt) begin fails++; $display("FAIL eh_cnt_frozen got %0d exp %0d", stall_count, exp_cnt); end
    ext_hold = 0; #1;
    n++; if (stall_id !== 1'b1) begin fails++; $display("FAIL eh_resume got %b exp 1", stall_id); end
    tick(); exp_cnt++;
    n++; if ({stall_id, fwd_a_sel, branch_taken} !== 4'b0101) begin fails++; $display("FAIL eh_after got %b exp 0101", {stall_id, fwd_a_sel, branch_taken}); end
    n++; if (stall_count !== exp_cnt) begin fails++; $display("FAIL eh_cnt got %0d exp %0d", stall_count, exp_cnt); end
    flush();
  endtask

  task automatic test_fwd_priority();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 13, 1, 0);
    tick(); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drv(1, 13, 13, 1, 1, 1, 0, 0, 0, 0, 0);
    n++; if ({stall_id, fwd_a_sel, fwd_b_sel} !== 5'b00101) begin fails++; $display("FAIL fp_mem_wins got %b exp 00101", {stall_id, fwd_a_sel, fwd_b_sel}); end
    id_is_branch = 0; #1;
    n++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin fails++; $display("FAIL fp_nonbranch got %b exp 0000", {fwd_a_sel, fwd_b_sel}); end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drv(1, 13, 13, 1, 1, 1, 0, 0, 0, 0, 0);
    n++; if ({fwd_a_sel, fwd_b_sel} !== 4'b1010) begin fails++; $display("FAIL fp_wb got %b exp 1010", {fwd_a_sel, fwd_b_sel}); end
    flush();
  endtask

  task automatic test_reset_mid_stall();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 8, 1, 1);
    tick();
    drv(1, 8, 0, 1, 0, 0, 0, 0, 14, 1, 0);
    n++; if (stall_id !== 1'b1) begin fails++; $display("FAIL rm_pre got %b exp 1", stall_id); end
    rst = 0; #1; exp_cnt = 0;
    n++; if ({stall_id, bubble_ex} !== 2'b00) begin fails++; $display("FAIL rm_cancel got %b exp 00", {stall_id, bubble_ex}); end
    n++; if (stall_count !== exp_cnt) begin fails++; $display("FAIL rm_cnt got %0d exp 0", stall_count); end
    rst = 1;
    drv(1, 0, 0, 0, 0, 0, 0, 0, 8, 1, 1);
    tick();
    drv(1, 8, 0, 1, 0, 0, 0, 0, 14, 1, 0);
    n++; if (stall_id !== 1'b1) begin fails++; $display("FAIL rm_first_edge got %b exp 1", stall_id); end
    tick(); exp_cnt++;
    n++; if (stall_count !== exp_cnt) begin fails++; $display("FAIL rm_cnt_after got %0d exp %0d", stall_count, exp_cnt); end
    flush();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < (1 << CW) + 5; i++) begin
      drv(1, 0, 0, 0, 0, 0, 0, 0, 8, 1, 1);
      tick();
      drv(1, 8, 0, 1, 0, 0, 0, 0, 14, 1, 0);
      tick();
    end
    n++; if (stall_count !== {CW{1'b1}}) begin fails++; $display("FAIL sat_cnt got %0d exp %0d", stall_count, {CW{1'b1}}); end
    flush();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_beq();
    test_load_bne();
    test_zero_dst();
    test_ext_hold();
    test_fwd_priority();
    test_reset_mid_stall();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
